reg_scoreboard: RTL and testbench

//  Register-hazard scoreboard for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/reg_scoreboard_if.sv | 35 +++
 rtl/reg_scoreboard.sv | 101 ++++++++++
 tb/tb_reg_scoreboard.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_scoreboard_if                                               |
// | Brief    : ID-issue / WB-retire bundle between pipeline and scoreboard     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface reg_scoreboard_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic        id_rs1_used;
    logic [4:0]  id_rs2;
    logic        id_rs2_used;
    logic [4:0]  id_dest;
    logic        id_gr_we;
    logic        id_issue;
    logic        wb_valid;
    logic        wb_gr_we;
    logic [4:0]  wb_dest;
    logic        id_stall;
    logic [31:0] busy_vec;
    logic        sb_err;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_dest, id_gr_we, id_issue, wb_valid, wb_gr_we, wb_dest,
        input  id_stall, busy_vec, sb_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_dest, id_gr_we, id_issue, wb_valid, wb_gr_we, wb_dest,
        output id_stall, busy_vec, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_scoreboard                                                  |
// | Brief    : GPR in-flight-writer scoreboard producing the ID-stage stall    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module reg_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    reg_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt      [1:31];
    logic [31:1]      r_busy_vec;
    logic             r_sb_err;

    logic [CNT_W-1:0] w_cnt_nxt  [1:31];
    logic [31:0]      w_nz;
    logic [31:0]      w_max;
    logic [31:0]      w_busy;
    logic             w_raw;
    logic             w_full;
    logic             w_stall;
    logic             w_issue_wr;
    logic             w_wb_wr;
    logic             w_violation;
    logic             w_underflow;

    // r0 is never tracked: its slot in every lookup vector is hard-wired idle
    assign w_nz[0]   = 1'b0;
    assign w_max[0]  = 1'b0;
    assign w_busy[0] = 1'b0;

    assign w_wb_wr    = sb.wb_valid & sb.wb_gr_we;
    assign w_issue_wr = sb.id_issue & sb.id_gr_we & ~w_stall;

    generate
        for (genvar i = 1; i < 32; i++) begin : g_reg
            logic             w_inc;
            logic             w_dec;
            logic             w_one;
            logic [CNT_W-1:0] w_nxt;

            assign w_nz[i]  = (r_cnt[i] != '0);
            assign w_max[i] = (r_cnt[i] == c_CNT_MAX);
            assign w_one    = (r_cnt[i] == c_CNT_ONE);
            assign w_inc    = w_issue_wr & (sb.id_dest == 5'(i));
            assign w_dec    = w_wb_wr & (sb.wb_dest == 5'(i)) & w_nz[i];

            // with write-through, the last writer retiring now no longer blocks a reader
            assign w_busy[i] = w_nz[i] & ~(WB_BYPASS & w_one & w_dec);

            always_comb begin
                w_nxt = r_cnt[i];
                if (w_inc & ~w_dec) begin
                    w_nxt = r_cnt[i] + c_CNT_ONE;
                end else if (~w_inc & w_dec) begin
                    w_nxt = r_cnt[i] - c_CNT_ONE;
                end
            end

            assign w_cnt_nxt[i] = w_nxt;
        end
    endgenerate

    assign w_raw   = (sb.id_rs1_used & w_busy[sb.id_rs1])
                   | (sb.id_rs2_used & w_busy[sb.id_rs2]);
    assign w_full  = sb.id_gr_we & w_max[sb.id_dest];
    assign w_stall = sb.id_valid & (w_raw | w_full);

    assign w_violation = sb.id_issue & w_stall;
    assign w_underflow = w_wb_wr & (sb.wb_dest != 5'd0) & ~w_nz[sb.wb_dest];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
            r_busy_vec <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i]      <= w_cnt_nxt[i];
                r_busy_vec[i] <= (w_cnt_nxt[i] != '0);
            end
            r_sb_err <= r_sb_err | w_violation | w_underflow;
        end
    end

    assign sb.id_stall = w_stall;
    assign sb.busy_vec = {r_busy_vec, 1'b0};
    assign sb.sb_err   = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reg_scoreboard                                               |
// | Brief    : directed + random bench for reg_scoreboard vs. counting model   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_reg_scoreboard;

    localparam int CNT_W = 2;
    localparam bit BYP   = 1'b0;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        bit       v;
        bit [4:0] rs1;
        bit       u1;
        bit [4:0] rs2;
        bit       u2;
        bit [4:0] dst;
        bit       we;
        bit       iss;
        bit       wv;
        bit       wwe;
        bit [4:0] wd;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_scoreboard_if sb_if ();

    reg_scoreboard #(
        .CNT_W     (CNT_W),
        .WB_BYPASS (BYP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    int m_cnt [32];
    bit m_err;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t mk(input bit v, input int rs1, input bit u1, input int rs2,
                                 input bit u2, input int dst, input bit we, input bit iss,
                                 input bit wv, input bit wwe, input int wd);
        stim_t s;
        s.v = v; s.rs1 = 5'(rs1); s.u1 = u1; s.rs2 = 5'(rs2); s.u2 = u2;
        s.dst = 5'(dst); s.we = we; s.iss = iss;
        s.wv = wv; s.wwe = wwe; s.wd = 5'(wd);
        return s;
    endfunction

    function automatic bit m_busy(input int r, input stim_t s);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
        if (BYP && m_cnt[r] == 1 && s.wv && s.wwe && int'(s.wd) == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall(input stim_t s);
        bit raw, full;
        raw  = (s.u1 && m_busy(int'(s.rs1), s)) || (s.u2 && m_busy(int'(s.rs2), s));
        full = s.we && s.dst != 0 && m_cnt[s.dst] == CMAX;
        return s.v && (raw || full);
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic drive(input stim_t s);
        sb_if.id_valid    = s.v;
        sb_if.id_rs1      = s.rs1;
        sb_if.id_rs1_used = s.u1;
        sb_if.id_rs2      = s.rs2;
        sb_if.id_rs2_used = s.u2;
        sb_if.id_dest     = s.dst;
        sb_if.id_gr_we    = s.we;
        sb_if.id_issue    = s.iss;
        sb_if.wb_valid    = s.wv;
        sb_if.wb_gr_we    = s.wwe;
        sb_if.wb_dest     = s.wd;
    endtask

    task automatic step(input stim_t s, output bit st);
        bit es;
        int inc_r, dec_r;
        @(negedge clk);
        drive(s);
        #1;
        es = m_stall(s);
        st = sb_if.id_stall;
        chk("id_stall", 32'(st), 32'(es));
        inc_r = 0;
        dec_r = 0;
        if (s.iss && es) m_err = 1'b1;
        else if (s.iss && s.we && s.dst != 0) inc_r = int'(s.dst);
        if (s.wv && s.wwe && s.wd != 0) begin
            if (m_cnt[s.wd] == 0) m_err = 1'b1;
            else dec_r = int'(s.wd);
        end
        if (inc_r != 0) m_cnt[inc_r]++;
        if (dec_r != 0) m_cnt[dec_r]--;
        @(posedge clk);
        #1;
        chk("busy_vec", sb_if.busy_vec, m_busy_vec());
        chk("sb_err", 32'(sb_if.sb_err), 32'(m_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 1'b0;
        chk("rst_busy", sb_if.busy_vec, 32'h0);
        chk("rst_err", 32'(sb_if.sb_err), 32'h0);
    endtask

    initial begin
        bit    st;
        stim_t s;
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 1'b0;
        repeat (2) @(posedge clk);

        // reset state: no stall whatever the sources
        do_reset();
        step(mk(1, 17, 1, 31, 1, 9, 1, 0, 0, 0, 0), st);
        chk("t1_stall", 32'(st), 32'h0);

        // dependent successor waits through the retire cycle
        do_reset();
        step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0), st);
        for (int c = 1; c <= 3; c++) begin
            step(mk(1, 5, 1, 0, 0, 6, 1, 0, c == 3, 1, 5), st);
            chk("t2_stall", 32'(st), 32'h1);
        end
        step(mk(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0), st);
        chk("t2_go", 32'(st), 32'h0);

        // WAW: two writers to r7
        do_reset();
        step(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0), st);
        step(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0), st);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7), st);
        chk("t3_busy1", 32'(sb_if.busy_vec[7]), 32'h1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7), st);
        chk("t3_busy0", 32'(sb_if.busy_vec[7]), 32'h0);
        chk("t3_err", 32'(sb_if.sb_err), 32'h0);

        // same-cycle issue and retire of r3
        do_reset();
        step(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0), st);
        step(mk(1, 0, 0, 0, 0, 3, 1, 1, 1, 1, 3), st);
        chk("t4_busy", 32'(sb_if.busy_vec[3]), 32'h1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3), st);
        chk("t4_cnt1", 32'(sb_if.busy_vec[3]), 32'h0);

        // counter saturation on r9
        do_reset();
        repeat (3) step(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0), st);
        step(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0), st);
        chk("t5_full", 32'(st), 32'h1);
        step(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0), st);
        chk("t5_err", 32'(sb_if.sb_err), 32'h1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9), st);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9), st);
        chk("t5_busy2", 32'(sb_if.busy_vec[9]), 32'h1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9), st);
        chk("t5_busy3", 32'(sb_if.busy_vec[9]), 32'h0);

        // r0 is inert; retiring an idle r12 is an underflow
        do_reset();
        step(mk(1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0), st);
        chk("t6_r0_stall", 32'(st), 32'h0);
        chk("t6_r0_busy", sb_if.busy_vec, 32'h0);
        chk("t6_r0_err", 32'(sb_if.sb_err), 32'h0);
        step(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0), st);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12), st);
        chk("t6_uf_err", 32'(sb_if.sb_err), 32'h1);
        chk("t6_uf_busy", sb_if.busy_vec, 32'h10);

        // random traffic over a small register window to provoke hazards
        for (int k = 0; k < 600; k++) begin
            if (k % 150 == 0) do_reset();
            s.v   = ($urandom % 4) != 0;
            s.rs1 = 5'($urandom % 8);
            s.u1  = $urandom % 2;
            s.rs2 = 5'($urandom % 8);
            s.u2  = $urandom % 2;
            s.dst = 5'($urandom % 8);
            s.we  = ($urandom % 4) != 0;
            s.wv  = $urandom % 2;
            s.wwe = ($urandom % 4) != 0;
            s.wd  = 5'($urandom % 8);
            if (s.wd != 0 && m_cnt[s.wd] == 0 && ($urandom % 16) != 0) s.wv = 1'b0;
            s.iss = s.v && (!m_stall(s) || ($urandom % 40) == 0);
            step(s, st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
